// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer and the downstream shift register.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  localparam logic DIR_LEFT    = 1'b0;
  localparam logic DIR_RIGHT   = 1'b1;
  localparam int   SHIFT_WIDTH = 4;

endpackage

// File: rtl/shift_seq.sv
// Command-driven serialiser feeding a left/right shift register one bit per cycle,
// with a one-cycle done pulse once the commanded number of strobes has been issued.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             hold,
  output logic             shift_left,
  output logic             shift_right,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output seq_state_t       dbg_state
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  seq_state_t       r_state;
  logic [WIDTH-1:0] r_sh;
  logic [LEN_W-1:0] r_cnt;
  logic             r_dir_q;

  logic [LEN_W-1:0] w_len_sat;
  logic             w_active;

  assign w_len_sat = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so command inputs are ignored elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_dir_q <= DIR_LEFT;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_sh    <= cmd_data;
            r_dir_q <= cmd_dir;
            r_cnt   <= w_len_sat;
            r_state <= (w_len_sat != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          if (!hold) begin
            r_sh  <= (r_dir_q == DIR_LEFT) ? (r_sh << 1) : (r_sh >> 1);
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == LEN_W'(1)) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes and the lane are decoded from registered state so the bit and its
  // strobe are sampled downstream on the same edge that advances r_sh.
  assign w_active    = (r_state == SHIFT) && !hold;
  assign shift_left  = w_active && (r_dir_q == DIR_LEFT);
  assign shift_right = w_active && (r_dir_q == DIR_RIGHT);

  always_comb begin
    data_out = '0;
    if (shift_left)  data_out[WIDTH-1] = r_sh[WIDTH-1];
    if (shift_right) data_out[0]       = r_sh[0];
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: doc/shift_seq.md
# shift_seq

Command-driven sequencer placed directly upstream of the team's 4-bit left/right shift register. It accepts a parallel word plus a direction and a bit count over a valid/ready handshake, then serialises the word one bit per cycle. The bits are presented on the lane the shift register samples: bit 3 for left shifts, bit 0 for right shifts. It drives the matching shift strobe for exactly the commanded number of cycles and pulses `done` on completion.

## Interface
- `WIDTH`, 4: word width; equals the downstream shift register width.
- `LEN_W`, 3: width of `cmd_len`; must hold the value `WIDTH`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command.
- `cmd_dir` input 1: 0 = left (MSB-first), 1 = right (LSB-first).
- `cmd_len` input LEN_W: number of bits to shift, 0..WIDTH; values above WIDTH saturate to WIDTH.
- `cmd_data` input WIDTH: word to serialise.
- `hold` input 1: stall; while high, no shift is issued and progress freezes.
- `shift_left` output 1: left strobe to the shift register.
- `shift_right` output 1: right strobe to the shift register.
- `data_out` output WIDTH: serial lane to the shift register `data_in`.
- `busy` output 1: a command is in progress (state ≠ IDLE).
- `done` output 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - SHIFT: strobes issued.
  - DONE: `done`=1 for one cycle.
- Acceptance: a command is accepted on a rising edge with `cmd_valid` && `cmd_ready`.
  - `cmd_data` is latched into shadow register `sh`, the direction into `dir_q`, and the saturated length into counter `cnt`.
  - Next state is SHIFT if the saturated length > 0, otherwise DONE.
- SHIFT, `hold`=0:
  - Drive `shift_left` = ~`dir_q` and `shift_right` = `dir_q`.
  - Left: `data_out` = {`sh`[WIDTH-1], zeros}. Right: `data_out` = {zeros, `sh`[0]}.
  - At the clock edge, `sh` shifts toward the next bit (left: `sh` << 1; right: `sh` >> 1, zero fill) and `cnt` decrements.
  - When `cnt` == 1 at that edge, next state is DONE.
- SHIFT, `hold`=1: both strobes are 0, `data_out` = 0, and `sh` and `cnt` are unchanged.
- DONE: `done`=1, strobes 0, `cmd_ready`=0; next state is IDLE unconditionally. `hold` is ignored.
- Strobe exclusivity: `shift_left` and `shift_right` are never high together.
- `data_out` in idle: 0 whenever neither strobe is high.
- `hold` outside SHIFT: no effect.
- Command inputs outside IDLE: ignored, because `cmd_ready`=0.
- Reset: asynchronous assertion at any time, including mid-SHIFT.
  - State returns to IDLE, `sh`=0, `cnt`=0, `dir_q`=0.
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - No partial command survives; any in-flight command is discarded and produces no `done`.
- Reset values: `cmd_ready`=1 (once reset is released), `shift_left`=0, `shift_right`=0, `data_out`=0, `busy`=0, `done`=0.

## Timing
- Accept edge at cycle t.
- First strobe: high during cycle t+1 (registered state; strobes decoded from the state plus `hold`).
- With no hold, strobes are high in cycles t+1 .. t+len, `done` is high in cycle t+len+1, and `cmd_ready` returns in cycle t+len+2.
- Each `hold` cycle during SHIFT extends the sequence by exactly one cycle.
- len 0: `done` is high in cycle t+1, with no strobes.
- Back-to-back throughput: one command per len+2 cycles.
- The downstream register samples `data_out` and the strobe on the same edge that advances `sh`, so the bit and its strobe are always coherent.

## Structure
- Shared package `shift_pkg` holds:
  - state enum `seq_state_t` {IDLE, SHIFT, DONE};
  - constants `DIR_LEFT`=1'b0 and `DIR_RIGHT`=1'b1;
  - default `SHIFT_WIDTH`=4.
- The downstream shift register also uses `SHIFT_WIDTH`.
- Single module; no sub-module is needed. The counter and shadow register are inline.
- All state is in one registered always block with async active-low reset. Outputs are decoded combinationally from the registered state, `dir_q`, `sh` and `hold`.

## Test plan
- Reset release, then `cmd_valid`, `cmd_dir`=0, `cmd_len`=4, `cmd_data`=4'b1011 → `shift_left` high for 4 cycles with `data_out` = 1000, 0000, 1000, 1000; `done` in cycle 5 after accept; a downstream shift register that starts at 0 ends at 4'b1011.
- `cmd_dir`=1, `cmd_len`=3, `cmd_data`=4'b0110 → `shift_right` high for 3 cycles with `data_out` = 0000, 0001, 0001; `done` in cycle 4 after accept.
- `cmd_len`=2 with `hold` high for 2 cycles between the first and second strobe → exactly 2 strobes, `done` delayed by 2 cycles, no strobe during hold.
- `cmd_len`=0 → no strobes, `done` in cycle t+1; `cmd_len`=7 → saturates to 4 strobes.
- `rst_n` pulsed low during the 2nd strobe of a len-4 command → strobes drop immediately, no `done`, `cmd_ready`=1 after release, and the next command runs normally.
- `cmd_valid` held high continuously → commands accepted only in IDLE, at len+2 spacing; `shift_left` and `shift_right` never high together.
